// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Bus between a memory controller and mem_responder.
//
// Signals
//   memRead   : read request (controller -> responder)
//   memWrite  : write request (controller -> responder)
//   address   : word address, ADDR_W bits (controller -> responder)
//   writeData : store data, DATA_W bits (controller -> responder)
//   readData  : registered read data (responder -> controller)
//   memReady  : one-cycle completion pulse (responder -> controller)
//   reqErr    : one-cycle illegal-request pulse (responder -> controller)
//
// Modports
//   master : controller side
//   slave  : responder side
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              memReady;
  logic              reqErr;

  modport master (
    output memRead,
    output memWrite,
    output address,
    output writeData,
    input  readData,
    input  memReady,
    input  reqErr
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  address,
    input  writeData,
    output readData,
    output memReady,
    output reqErr
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-port word memory behind a request/ready handshake, controlled by an
// IDLE/BUSY/DONE state machine.
//
// Ports
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-low reset
//   bus : mem_responder_if.slave (memRead, memWrite, address, writeData in;
//         readData, memReady, reqErr out)
//
// Parameters
//   ADDR_W      : word-address width, memory depth is 2**ADDR_W words
//   DATA_W      : word width
//   WAIT_CYCLES : wait states per access (1..15), only used with the
//                 MEM_RESP_WAIT_EN macro
//
// Configuration macro
//   MEM_RESP_WAIT_EN : when defined, the BUSY state and wait counter are
//                      built and every access takes WAIT_CYCLES extra cycles.
//                      When undefined, IDLE goes straight to DONE and the
//                      access completes on the accepting edge.
//
// Notes
//   - The memory array has no reset; rst only returns the controller state
//     and the output registers to their idle values.
//   - readData changes only on completed reads.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Out-of-range wait settings stop elaboration instead of silently wrapping
  // the 4-bit wait counter.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range_bad
    $error("mem_responder: WAIT_CYCLES must be within 1..15");
  end

`ifdef MEM_RESP_WAIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_t            state_r;
  state_t            state_nxt_s;

  logic              req_one_s;     // exactly one request line high
  logic              req_both_s;    // illegal read+write request
  logic              enter_done_s;  // this edge completes the access
  logic              req_err_s;

  logic [ADDR_W-1:0] acc_addr_s;    // address used by the completing access
  logic [DATA_W-1:0] acc_data_s;    // data used by the completing access
  logic              acc_wr_s;      // completing access is a write
  logic              mem_we_s;

  logic [DATA_W-1:0] read_data_r;
  logic              mem_ready_r;
  logic              req_err_r;

  logic [DATA_W-1:0] mem_r [DEPTH];

`ifdef MEM_RESP_WAIT_EN
  logic              req_any_s;
  logic              accept_s;      // IDLE edge that takes a new request
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              wr_r;
`endif

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign req_one_s  = bus.memRead ^ bus.memWrite;
  assign req_both_s = bus.memRead & bus.memWrite;
`ifdef MEM_RESP_WAIT_EN
  assign req_any_s  = bus.memRead | bus.memWrite;
`endif

  // Illegal request is only reported when it would otherwise be accepted.
  assign req_err_s = (state_r == IDLE) & req_both_s;

`ifdef MEM_RESP_WAIT_EN
  // The access runs on the values captured when it was accepted; bus changes
  // during BUSY are ignored.
  assign acc_addr_s = addr_r;
  assign acc_data_s = data_r;
  assign acc_wr_s   = wr_r;
`else
  // Without wait states the access completes on the accepting edge, so the
  // captured values are the bus values at that same edge.
  assign acc_addr_s = bus.address;
  assign acc_data_s = bus.writeData;
  assign acc_wr_s   = bus.memWrite;
`endif

  // Gating with rst keeps a request held during reset from writing memory.
  assign mem_we_s = enter_done_s & acc_wr_s & rst;

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  // Next state, wait counter and access-complete strobe
  always_comb begin
    state_nxt_s  = state_r;
    enter_done_s = 1'b0;
`ifdef MEM_RESP_WAIT_EN
    accept_s     = 1'b0;
    cnt_nxt_s    = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_one_s) begin
`ifdef MEM_RESP_WAIT_EN
          accept_s     = 1'b1;
          state_nxt_s  = BUSY;
          cnt_nxt_s    = CNT_INIT;
`else
          enter_done_s = 1'b1;
          state_nxt_s  = DONE;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef MEM_RESP_WAIT_EN
      BUSY: begin
        if (!req_any_s) begin
          // Controller withdrew the request: abandon without touching memory.
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r != 4'd0) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = cnt_r - 4'd1;
        end else begin
          state_nxt_s  = DONE;
          enter_done_s = 1'b1;
        end
      end
`endif
      DONE: begin
        // Requests seen here are ignored; the next one is taken from IDLE.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef MEM_RESP_WAIT_EN
  // Wait counter and request capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= 4'd0;
      addr_r <= '0;
      data_r <= '0;
      wr_r   <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (accept_s) begin
        addr_r <= bus.address;
        data_r <= bus.writeData;
        wr_r   <= bus.memWrite;
      end
    end
  end
`endif

  // Registered outputs: read data, completion pulse, error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_r <= '0;
      mem_ready_r <= 1'b0;
      req_err_r   <= 1'b0;
    end else begin
      // memReady is high exactly while the FSM sits in DONE.
      mem_ready_r <= enter_done_s;
      req_err_r   <= req_err_s;
      if (enter_done_s && !acc_wr_s) begin
        read_data_r <= mem_r[acc_addr_s];
      end
    end
  end

  // Memory write port; no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[acc_addr_s] <= acc_data_s;
    end
  end

  assign bus.readData = read_data_r;
  assign bus.memReady = mem_ready_r;
  assign bus.reqErr   = req_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Two instances: dut_a (WAIT_CYCLES=2) and
// dut_b (WAIT_CYCLES=3). Stimulus tasks push the expected completion cycle
// and read value into a queue per instance; monitor processes pop and compare
// whenever memReady or reqErr is seen. Expectations follow the build:
// MEM_RESP_WAIT_EN defined gives W = WAIT_CYCLES, otherwise W = 0.
// ---------------------------------------------------------------------------
module tb_mem_responder;

`ifdef MEM_RESP_WAIT_EN
  localparam int WA = 2;
  localparam int WB = 3;
`else
  localparam int WA = 0;
  localparam int WB = 0;
`endif

  typedef struct packed {
    logic        is_rd;
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rd_d [2];
  logic        wr_d [2];
  logic [11:0] ad_d [2];
  logic [15:0] wd_d [2];

  int          cyc;
  int          total;
  int          bad;

  exp_t        qa [$];
  exp_t        qb [$];
  int          erra [$];
  int          errb [$];

  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifa ();
  mem_responder_if #(.ADDR_W(12), .DATA_W(16)) ifb ();

  assign ifa.memRead   = rd_d[0];
  assign ifa.memWrite  = wr_d[0];
  assign ifa.address   = ad_d[0];
  assign ifa.writeData = wd_d[0];
  assign ifb.memRead   = rd_d[1];
  assign ifb.memWrite  = wr_d[1];
  assign ifb.address   = ad_d[1];
  assign ifb.writeData = wd_d[1];

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one access. in_done=1 means we are in the DONE cycle of the
  // previous access, so the request is ignored for one edge first.
  // With chg=1 the address/data/type are disturbed right after acceptance.
  // Returns #1 after the edge that enters DONE, requests still driven.
  task automatic access(input int sel, input bit wr, input logic [11:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd,
                        input bit in_done, input bit chg,
                        input logic [11:0] ca, input logic [15:0] cd);
    int   w;
    int   e0;
    exp_t e;
    w  = (sel == 0) ? WA : WB;
    e0 = cyc + (in_done ? 2 : 1);
    rd_d[sel] = ~wr;
    wr_d[sel] = wr;
    ad_d[sel] = a;
    wd_d[sel] = d;
    e.is_rd = ~wr;
    e.data  = exp_rd;
    e.due   = 32'(e0 + w);
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
    while (cyc < e0 + w) begin
      @(posedge clk);
      #1;
      if (chg && cyc == e0) begin
        ad_d[sel] = ca;
        wd_d[sel] = cd;
        rd_d[sel] = 1'b0;
        wr_d[sel] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int sel);
    rd_d[sel] = 1'b0;
    wr_d[sel] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor for dut_a
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifa.memReady === 1'b1) begin
        if (qa.size() == 0) begin
          chk("a_ready_spurious", 32'(ifa.memReady), 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_ready_cycle", 32'(cyc), e.due);
          if (e.is_rd) chk("a_readData", 32'(ifa.readData), 32'(e.data));
        end
      end
      if (ifa.reqErr === 1'b1) begin
        if (erra.size() == 0) chk("a_reqErr_spurious", 32'(ifa.reqErr), 32'd0);
        else                  chk("a_reqErr_cycle", 32'(cyc), 32'(erra.pop_front()));
      end
    end
  end

  // Monitor for dut_b
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifb.memReady === 1'b1) begin
        if (qb.size() == 0) begin
          chk("b_ready_spurious", 32'(ifb.memReady), 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_ready_cycle", 32'(cyc), e.due);
          if (e.is_rd) chk("b_readData", 32'(ifb.readData), 32'(e.data));
        end
      end
      if (ifb.reqErr === 1'b1) begin
        if (errb.size() == 0) chk("b_reqErr_spurious", 32'(ifb.reqErr), 32'd0);
        else                  chk("b_reqErr_cycle", 32'(cyc), 32'(errb.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    cyc   = 0;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_d[i] = 1'b0;
      wr_d[i] = 1'b0;
      ad_d[i] = 12'h000;
      wd_d[i] = 16'h0000;
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readData", 32'(ifa.readData), 32'h0);
    chk("rst_memReady", 32'(ifa.memReady), 32'h0);
    chk("rst_reqErr",   32'(ifa.reqErr),   32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back, two data patterns
    access(0, 1'b1, 12'h005, 16'h0ABC, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    access(0, 1'b0, 12'h005, 16'h0000, 16'h0ABC, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    access(0, 1'b1, 12'h005, 16'h1234, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    access(0, 1'b0, 12'h005, 16'h0000, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);

    // Read and write together in IDLE: one reqErr pulse, no access
    rd_d[0] = 1'b1;
    wr_d[0] = 1'b1;
    ad_d[0] = 12'h005;
    wd_d[0] = 16'h7777;
    erra.push_back(cyc + 1);
    @(posedge clk);
    #1;
    rd_d[0] = 1'b0;
    wr_d[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("both_readData_kept", 32'(ifa.readData), 32'h1234);
    access(0, 1'b0, 12'h005, 16'h0000, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);

`ifdef MEM_RESP_WAIT_EN
    // Reset during BUSY of a write: nothing committed, outputs cleared
    access(0, 1'b1, 12'h020, 16'h0111, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    rd_d[0] = 1'b0;
    wr_d[0] = 1'b1;
    ad_d[0] = 12'h020;
    wd_d[0] = 16'h00FF;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("busy_rst_readData", 32'(ifa.readData), 32'h0);
    chk("busy_rst_memReady", 32'(ifa.memReady), 32'h0);
    wr_d[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    access(0, 1'b0, 12'h020, 16'h0000, 16'h0111, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
`else
    // Reset in IDLE clears readData
    rst = 1'b0;
    #1;
    chk("idle_rst_readData", 32'(ifa.readData), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
`endif

    // Memory survives reset
    access(0, 1'b0, 12'h005, 16'h0000, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);

    // Bus disturbed during the access, then a back-to-back read from DONE
    access(0, 1'b1, 12'h001, 16'h0101, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    access(0, 1'b1, 12'h002, 16'h0202, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(0);
    access(0, 1'b0, 12'h001, 16'h0000, 16'h0101, 1'b0, 1'b1, 12'h002, 16'hDEAD);
    access(0, 1'b0, 12'h002, 16'h0000, 16'h0202, 1'b1, 1'b0, 12'h000, 16'h0000);
    idle(0);

    // dut_b: prior contents at 0x010
    access(1, 1'b1, 12'h010, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(1);
`ifdef MEM_RESP_WAIT_EN
    // Write of 0xFFFF withdrawn after the first BUSY cycle
    rd_d[1] = 1'b0;
    wr_d[1] = 1'b1;
    ad_d[1] = 12'h010;
    wd_d[1] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 wr_d[1] = 1'b0;
    @(posedge clk);
    #1;
    // Read issued at once: the timing check only holds if the FSM is in IDLE
`endif
    access(1, 1'b0, 12'h010, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(1);

    repeat (6) @(posedge clk);
    #1;
    chk("a_pending_ready", 32'(qa.size()),   32'd0);
    chk("b_pending_ready", 32'(qb.size()),   32'd0);
    chk("a_pending_err",   32'(erra.size()), 32'd0);
    chk("b_pending_err",   32'(errb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the word-address width; memory depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, SHALL set the word width.
REQ-003 Parameter WAIT_CYCLES, default 2, range 1..15, SHALL set the number of wait-state cycles; it is used only with MEM_RESP_WAIT_EN.
REQ-004 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port memRead, input, 1: read request from the controller.
REQ-007 Port memWrite, input, 1: write request from the controller.
REQ-008 Port address, input, ADDR_W: word address.
REQ-009 Port writeData, input, DATA_W: store data.
REQ-010 Port readData, output, DATA_W: registered read data.
REQ-011 Port memReady, output, 1: one-cycle completion pulse for an access.
REQ-012 Port reqErr, output, 1: one-cycle pulse flagging an illegal request.

Function
REQ-013 The block SHALL be a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE, the edge E0 that samples exactly one of memRead/memWrite high SHALL latch address, writeData and the access type into internal registers.
REQ-015 After E0, the FSM SHALL enter BUSY with its wait counter set to WAIT_CYCLES-1 when wait states are enabled, and SHALL enter DONE directly otherwise.
REQ-016 At each BUSY edge, if neither memRead nor memWrite is high, the FSM SHALL abort to IDLE with no memory access and no memReady pulse.
REQ-017 Otherwise, at a BUSY edge the counter SHALL decrement when nonzero; when it is 0, the FSM SHALL enter DONE.
REQ-018 On the edge entering DONE, a write SHALL commit mem[latched address] <= latched data, and a read SHALL load readData <= mem[latched address].
REQ-019 memReady SHALL be 1 only while the FSM is in DONE, which lasts exactly one cycle.
REQ-020 Latency: memReady SHALL be high in the cycle following edge E0+W, where W = WAIT_CYCLES with the macro defined and W = 0 without it.
REQ-021 The FSM SHALL go from DONE to IDLE unconditionally; requests present in DONE SHALL be ignored, so the earliest next acceptance is the following edge.
REQ-022 memRead and memWrite both high when sampled in IDLE SHALL cause no access and no state change, and SHALL set reqErr high for the next cycle.
REQ-023 During BUSY, changes on address, writeData or the request type SHALL have no effect; only the drop of both requests (REQ-016) matters.
REQ-024 readData SHALL hold its last value until the next completed read; writes and aborts SHALL leave it unchanged.
REQ-025 A read of an address written in an earlier completed access SHALL return the written value.
REQ-026 The memory array SHALL be uninitialised, and a read of a never-written word is undefined.

Reset
REQ-027 While rst is low, the block SHALL be in IDLE with the wait counter = 0, readData = 0, memReady = 0 and reqErr = 0.
REQ-028 Reset asserted mid-access SHALL abandon the access: no write is committed after assertion and no memReady is issued.
REQ-029 Reset SHALL NOT clear the memory array contents.

Configuration
REQ-030 With macro MEM_RESP_WAIT_EN defined, the BUSY state and wait counter SHALL be compiled in, giving WAIT_CYCLES wait states.
REQ-031 With MEM_RESP_WAIT_EN undefined, BUSY and the counter SHALL be absent, IDLE SHALL go directly to DONE, latency SHALL be 1 cycle, and REQ-016 SHALL not apply.

Verification
REQ-032 The bench SHALL cover, with MEM_RESP_WAIT_EN and WAIT_CYCLES=2: write 0x0ABC at address 0x005 with memWrite held, then read 0x005.
- Required: memReady high exactly in the cycles after E0+2 for each access.
- Required: readData = 0x0ABC.
REQ-033 The bench SHALL cover, without MEM_RESP_WAIT_EN: read 0x005 after writing 0x1234.
- Required: memReady high in the cycle after E0.
- Required: readData = 0x1234.
REQ-034 The bench SHALL cover: memRead and memWrite both 1 in IDLE.
- Required: reqErr = 1 for one cycle.
- Required: memReady stays 0, and memory and readData are unchanged.
REQ-035 The bench SHALL cover, with WAIT_CYCLES=3: write 0xFFFF at 0x010, with memWrite dropped after the first BUSY cycle.
- Required: no memReady pulse, and FSM back in IDLE.
- Required: a later read of 0x010 returns the prior contents.
REQ-036 The bench SHALL cover: rst driven low during BUSY of a write of 0x00FF at 0x020.
- Required: readData = 0, memReady = 0 immediately.
- Required: 0x020 is not modified.
REQ-037 The bench SHALL cover: during BUSY of a read of 0x001, change address to 0x002.
- Required: the read returns mem[0x001].
- Required: back-to-back requests are accepted on the edge after DONE.
